// File: rtl/basic_block_fifo.sv
// Regex execution lane: input-PC FIFO feeding a fetch/execute FSM that emits 0-2 successor PCs.
// Optional macro BB_ACCEPT_PARTIAL_EN adds the ACCEPT_PARTIAL opcode and the accept_pc output.
module basic_block_fifo #(
  parameter int PC_WIDTH          = 8,
  parameter int CHARACTER_WIDTH   = 8,
  parameter int INSTR_DATA_WIDTH  = 8,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHARACTER_WIDTH-1:0]   current_character,
  input  logic                         input_pc_valid,
  input  logic [PC_WIDTH-1:0]          input_pc,
  output logic                         input_pc_ready,
  output logic                         memory_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0] memory_addr,
  input  logic                         memory_ready,
  input  logic                         memory_rsp_valid,
  input  logic [MEMORY_WIDTH-1:0]      memory_data,
  output logic                         output_pc_valid,
  output logic [PC_WIDTH-1:0]          output_pc,
  output logic                         output_pc_is_directed_to_current,
  input  logic                         output_pc_ready,
  output logic                         accepts,
`ifdef BB_ACCEPT_PARTIAL_EN
  output logic [PC_WIDTH-1:0]          accept_pc,
`endif
  output logic                         idle,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  // state        | meaning
  // S_IDLE       | waiting for a PC in the FIFO; pops it on entry of work
  // S_FETCH_SEND | instruction request presented to memory
  // S_FETCH_WAIT | request accepted, waiting for the response strobe
  // S_EXEC_1     | opcode evaluated, first successor (if any) offered
  // S_EXEC_2     | SPLIT only: second successor offered
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [7:0] OP_END_WITHOUT_ACCEPTING = 8'd0;
  localparam logic [7:0] OP_ACCEPT                = 8'd1;
  localparam logic [7:0] OP_SPLIT                 = 8'd2;
  localparam logic [7:0] OP_MATCH                 = 8'd3;
  localparam logic [7:0] OP_JMP                   = 8'd4;
  localparam logic [7:0] OP_NOT_MATCH             = 8'd5;
  localparam logic [7:0] OP_MATCH_ANY             = 8'd6;
`ifdef BB_ACCEPT_PARTIAL_EN
  localparam logic [7:0] OP_ACCEPT_PARTIAL        = 8'd7;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_SEND,
    S_FETCH_WAIT,
    S_EXEC_1,
    S_EXEC_2
  } state_t;

  state_t state, state_next;

  logic [PC_WIDTH-1:0]         fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count;
  logic                        push, pop;

  logic [PC_WIDTH-1:0]         cur_pc;
  logic [7:0]                  instr_op;
  logic [INSTR_DATA_WIDTH-1:0] instr_data;
  logic [PC_WIDTH-1:0]         pc_inc;
  logic                        char_eq, char_zero;

  assign input_pc_ready = (count != CW'(FIFO_DEPTH));
  assign push           = input_pc_valid && input_pc_ready;
  assign pop            = (state == S_IDLE) && (count != '0);
  assign fifo_count     = count;
  assign idle           = (state == S_IDLE) && (count == '0);
  assign memory_addr    = MEMORY_ADDR_WIDTH'(cur_pc);
  assign pc_inc         = cur_pc + PC_WIDTH'(1);
  assign char_eq        = (current_character == instr_data[CHARACTER_WIDTH-1:0]);
  assign char_zero      = (current_character == '0);
`ifdef BB_ACCEPT_PARTIAL_EN
  assign accept_pc      = cur_pc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= input_pc;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cur_pc     <= '0;
      instr_op   <= OP_END_WITHOUT_ACCEPTING;
      instr_data <= '0;
    end else begin
      state <= state_next;
      if (pop) cur_pc <= fifo_mem[rd_ptr];
      if (state == S_FETCH_WAIT && memory_rsp_valid) begin
        instr_op   <= memory_data[INSTR_DATA_WIDTH+7:INSTR_DATA_WIDTH];
        instr_data <= memory_data[INSTR_DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_next                       = state;
    memory_valid                     = 1'b0;
    output_pc_valid                  = 1'b0;
    output_pc                        = '0;
    output_pc_is_directed_to_current = 1'b0;
    accepts                          = 1'b0;
    case (state)
      S_IDLE:       if (count != '0) state_next = S_FETCH_SEND;
      S_FETCH_SEND: begin
        memory_valid = 1'b1;
        if (memory_ready) state_next = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: if (memory_rsp_valid) state_next = S_EXEC_1;
      S_EXEC_1: begin
        state_next = S_IDLE;
        case (instr_op)
          OP_ACCEPT: accepts = char_zero;
`ifdef BB_ACCEPT_PARTIAL_EN
          OP_ACCEPT_PARTIAL: accepts = 1'b1;
`endif
          OP_SPLIT: begin
            output_pc_valid                  = 1'b1;
            output_pc                        = pc_inc;
            output_pc_is_directed_to_current = 1'b1;
            state_next                       = S_EXEC_2;
          end
          OP_MATCH: begin
            output_pc_valid = char_eq;
            output_pc       = pc_inc;
          end
          OP_NOT_MATCH: begin
            output_pc_valid = !char_eq;
            output_pc       = pc_inc;
          end
          OP_MATCH_ANY: begin
            output_pc_valid = !char_zero;
            output_pc       = pc_inc;
          end
          OP_JMP: begin
            output_pc_valid                  = 1'b1;
            output_pc                        = instr_data[PC_WIDTH-1:0];
            output_pc_is_directed_to_current = 1'b1;
          end
          default: ;
        endcase
        // Hold the whole decision while the offered PC is back-pressured.
        if (output_pc_valid && !output_pc_ready) state_next = S_EXEC_1;
      end
      S_EXEC_2: begin
        output_pc_valid                  = 1'b1;
        output_pc                        = instr_data[PC_WIDTH-1:0];
        output_pc_is_directed_to_current = 1'b1;
        if (output_pc_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
